// File: rtl/act_pkg.sv
// Shared types and fixed-point constants for the pipelined activation unit.
// All constants are returned as 64-bit values and narrowed by the user.
package act_pkg;

  typedef enum logic [1:0] {
    MODE_LRELU   = 2'd0,
    MODE_SIGMOID = 2'd1,
    MODE_TANH    = 2'd2,
    MODE_PASS    = 2'd3
  } act_mode_t;

  function automatic longint one_q(input int frac_w);
    return 64'sd1 <<< frac_w;
  endfunction

  // Segment breakpoints of the PLAN approximation: 5.0, 2.375, 1.0.
  function automatic longint bp_hi(input int frac_w);
    return 64'sd5 * one_q(frac_w);
  endfunction

  function automatic longint bp_mid(input int frac_w);
    return (64'sd19 * one_q(frac_w)) >>> 3;
  endfunction

  function automatic longint bp_lo(input int frac_w);
    return one_q(frac_w);
  endfunction

  // Segment intercepts: 27/32, 5/8, 1/2 (exact because frac_w >= 5).
  function automatic longint ic_hi(input int frac_w);
    return (64'sd27 * one_q(frac_w)) >>> 5;
  endfunction

  function automatic longint ic_mid(input int frac_w);
    return (64'sd5 * one_q(frac_w)) >>> 3;
  endfunction

  function automatic longint ic_lo(input int frac_w);
    return one_q(frac_w) >>> 1;
  endfunction

  function automatic longint sat_clamp(input longint v, input int w);
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/act_sigmoid_plan.sv
// Combinational PLAN sigmoid on a magnitude u with the sign applied last.
// Shared by SIGMOID (u = |x|) and TANH (u = |2x|).
module act_sigmoid_plan
  import act_pkg::*;
#(
  parameter int W      = 18,
  parameter int FRAC_W = 8
) (
  input  logic [W-1:0]        u_i,
  input  logic                neg_i,
  output logic signed [W-1:0] s_o
);

  localparam logic [W-1:0] ONE    = W'(one_q(FRAC_W));
  localparam logic [W-1:0] BP_HI  = W'(bp_hi(FRAC_W));
  localparam logic [W-1:0] BP_MID = W'(bp_mid(FRAC_W));
  localparam logic [W-1:0] BP_LO  = W'(bp_lo(FRAC_W));
  localparam logic [W-1:0] IC_HI  = W'(ic_hi(FRAC_W));
  localparam logic [W-1:0] IC_MID = W'(ic_mid(FRAC_W));
  localparam logic [W-1:0] IC_LO  = W'(ic_lo(FRAC_W));

  logic [W-1:0] s_mag;

  // u is non-negative, so logical and arithmetic shifts coincide.
  always_comb begin
    if (u_i >= BP_HI)       s_mag = ONE;
    else if (u_i >= BP_MID) s_mag = (u_i >> 5) + IC_HI;
    else if (u_i >= BP_LO)  s_mag = (u_i >> 3) + IC_MID;
    else                    s_mag = (u_i >> 2) + IC_LO;
    s_o = neg_i ? signed'(ONE - s_mag) : signed'(s_mag);
  end

endmodule

// File: rtl/act_unit_pipe.sv
// Three-stage fixed-point activation unit (LReLU/sigmoid/tanh/bypass) with
// valid/ready stall handling. Optional saturation counter: ACT_SAT_CNT_EN.
module act_unit_pipe
  import act_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int FRAC_W       = 8,
  parameter int STALL_EN_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [1:0]               in_mode,
  input  logic signed [DATA_W-1:0] alpha,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [15:0]              sat_cnt
);

  localparam int UW    = DATA_W + 2;
  localparam int RES_W = 2 * DATA_W;
  localparam logic signed [RES_W-1:0] ONE_R = RES_W'(one_q(FRAC_W));

  generate
    if (DATA_W < 8 || DATA_W > 32 || FRAC_W < 5 || FRAC_W > DATA_W - 3) begin : g_bad_cfg
      $fatal(1, "act_unit_pipe: illegal DATA_W/FRAC_W combination");
    end
  endgenerate

  // Handshake: a sample moves on a rising edge where valid && ready are both
  // high; a stage holds its contents whenever its enable is low.
  logic v1_q, v2_q, v3_q;
  logic en1, en2, en3;

  generate
    if (STALL_EN_REG != 0) begin : g_compact
      assign en3 = !v3_q || out_ready;
      assign en2 = !v2_q || en3;
      assign en1 = !v1_q || en2;
    end else begin : g_global
      assign en3 = !v3_q || out_ready;
      assign en2 = en3;
      assign en1 = en3;
    end
  endgenerate

  assign in_ready = en1;

  // Stage 1: capture the sample and its magnitude (|2x| for TANH).
  logic signed [DATA_W:0] xs;
  logic signed [UW-1:0]   x2;
  logic [DATA_W:0]        abs_x;
  logic [UW-1:0]          abs_2x;
  logic [UW-1:0]          u_d;
  logic                   neg_d;
  act_mode_t              mode_d;

  always_comb begin
    mode_d = act_mode_t'(in_mode);
    neg_d  = in_data[DATA_W-1];
    xs     = (DATA_W+1)'(in_data);
    x2     = UW'(in_data) <<< 1;
    abs_x  = neg_d ? -xs : xs;
    abs_2x = neg_d ? -x2 : x2;
    u_d    = (mode_d == MODE_TANH) ? abs_2x : UW'(abs_x);
  end

  logic signed [DATA_W-1:0] x1_q, a1_q;
  act_mode_t                m1_q;
  logic [UW-1:0]            u1_q;
  logic                     neg1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      x1_q   <= '0;
      a1_q   <= '0;
      m1_q   <= MODE_LRELU;
      u1_q   <= '0;
      neg1_q <= 1'b0;
    end else if (en1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        x1_q   <= in_data;
        a1_q   <= alpha;
        m1_q   <= mode_d;
        u1_q   <= u_d;
        neg1_q <= neg_d;
      end
    end
  end

  // Stage 2: evaluate the selected function at full product width.
  logic signed [UW-1:0]    s_plan;
  logic signed [RES_W-1:0] prod;
  logic signed [RES_W-1:0] res_d;
  logic                    x_pos;

  act_sigmoid_plan #(
    .W      (UW),
    .FRAC_W (FRAC_W)
  ) u_plan (
    .u_i   (u1_q),
    .neg_i (neg1_q),
    .s_o   (s_plan)
  );

  assign prod  = RES_W'(x1_q) * RES_W'(a1_q);
  assign x_pos = !x1_q[DATA_W-1] && (x1_q != '0);

  always_comb begin
    case (m1_q)
      MODE_LRELU:   res_d = x_pos ? RES_W'(x1_q) : (prod >>> FRAC_W);
      MODE_SIGMOID: res_d = RES_W'(s_plan);
      MODE_TANH:    res_d = (RES_W'(s_plan) <<< 1) - ONE_R;
      default:      res_d = RES_W'(x1_q);
    endcase
  end

  logic signed [RES_W-1:0] res2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q   <= 1'b0;
      res2_q <= '0;
    end else if (en2) begin
      v2_q <= v1_q;
      if (v1_q) res2_q <= res_d;
    end
  end

  // Stage 3: saturate to DATA_W and hold the result while stalled.
  logic signed [63:0]       res_l, clamped_l;
  logic signed [DATA_W-1:0] out_d;
  logic signed [DATA_W-1:0] out_q;

  always_comb begin
    res_l     = 64'(res2_q);
    clamped_l = sat_clamp(res_l, DATA_W);
    out_d     = DATA_W'(clamped_l);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q  <= 1'b0;
      out_q <= '0;
    end else if (en3) begin
      v3_q <= v2_q;
      if (v2_q) out_q <= out_d;
    end
  end

  assign out_valid = v3_q;
  assign out_data  = out_q;

`ifdef ACT_SAT_CNT_EN
  logic        clamp_d;
  logic        clamp3_q;
  logic [15:0] sat_q;

  assign clamp_d = (clamped_l != res_l);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clamp3_q <= 1'b0;
      sat_q    <= 16'd0;
    end else begin
      if (en3 && v2_q) clamp3_q <= clamp_d;
      if (v3_q && out_ready && clamp3_q && (sat_q != 16'hFFFF)) sat_q <= sat_q + 16'd1;
    end
  end

  assign sat_cnt = sat_q;
`else
  assign sat_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_act_unit_pipe.sv
// Directed bench for act_unit_pipe (DATA_W=16, FRAC_W=8): vector table,
// stall stream, mid-stream reset and a random PASS soak.
module tb_act_unit_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic [15:0] alpha;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [15:0] sat_cnt;

  act_unit_pipe #(
    .DATA_W       (16),
    .FRAC_W       (8),
    .STALL_EN_REG (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .alpha     (alpha),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat_cnt   (sat_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;
  logic [15:0] exp_q[$];
  bit          prev_stalled = 0;
  logic [15:0] prev_data = '0;
  bit          saw_in_ready_low = 0;

`ifdef ACT_SAT_CNT_EN
  localparam int SAT_INC = 1;
`else
  localparam int SAT_INC = 0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // reference model: {clamp, y}
  function automatic longint sig_ref(input longint v);
    longint u, s;
    u = (v < 0) ? -v : v;
    if (u >= 1280)     s = 256;
    else if (u >= 608) s = u / 32 + 216;
    else if (u >= 256) s = u / 8 + 160;
    else               s = u / 4 + 128;
    return (v < 0) ? 256 - s : s;
  endfunction

  function automatic logic [16:0] model(input logic [15:0] x, input logic [1:0] m, input logic [15:0] a);
    longint xi, ai, r;
    logic   c;
    xi = longint'($signed(x));
    ai = longint'($signed(a));
    case (m)
      2'd0:    r = (xi > 0) ? xi : ((xi * ai) >>> 8);
      2'd1:    r = sig_ref(xi);
      2'd2:    r = 2 * sig_ref(2 * xi) - 256;
      default: r = xi;
    endcase
    c = 1'b0;
    if (r > 32767)       begin r = 32767;  c = 1'b1; end
    else if (r < -32768) begin r = -32768; c = 1'b1; end
    return {c, r[15:0]};
  endfunction

  // driver: holds the sample until accepted, then queues its expected result
  task automatic send(input logic [15:0] x, input logic [1:0] m, input logic [15:0] a,
                      input logic [15:0] exp_y);
    int t;
    bit hs;
    in_valid = 1'b1;
    in_data  = x;
    in_mode  = m;
    alpha    = a;
    t  = 0;
    hs = 0;
    while (!hs && t < 200) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      t++;
    end
    if (hs) exp_q.push_back(exp_y);
    else begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, want accept", t);
    end
    #1;
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stalled = 0;
    end else begin
      if (prev_stalled) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got %h, want no output", out_data);
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
        n_out++;
      end
      prev_stalled = out_valid && !out_ready;
      prev_data    = out_data;
      if (in_valid && !in_ready) saw_in_ready_low = 1;
    end
  end

  typedef struct {
    logic [15:0] x;
    logic [1:0]  mode;
    logic [15:0] a;
    logic [15:0] y;
    bit          clamp;
  } vec_t;

  vec_t tbl[21];

  logic [15:0] sx[8];
  logic [1:0]  sm[8];
  logic [15:0] sa[8];

  initial begin
    int lat, exp_sat, n0, t, stale;
    bit got;
    bit done;
    logic [15:0] sat0;
    logic [15:0] rx;

    tbl[0]  = '{16'h0000, 2'd1, 16'h0000, 16'h0080, 1'b0};
    tbl[1]  = '{16'h0100, 2'd1, 16'h0000, 16'h00C0, 1'b0};
    tbl[2]  = '{16'hFF00, 2'd1, 16'h0000, 16'h0040, 1'b0};
    tbl[3]  = '{16'h0500, 2'd1, 16'h0000, 16'h0100, 1'b0};
    tbl[4]  = '{16'h00FF, 2'd1, 16'h0000, 16'h00BF, 1'b0};
    tbl[5]  = '{16'h025F, 2'd1, 16'h0000, 16'h00EB, 1'b0};
    tbl[6]  = '{16'h0260, 2'd1, 16'h0000, 16'h00EB, 1'b0};
    tbl[7]  = '{16'h04FF, 2'd1, 16'h0000, 16'h00FF, 1'b0};
    tbl[8]  = '{16'hFB00, 2'd1, 16'h0000, 16'h0000, 1'b0};
    tbl[9]  = '{16'h0100, 2'd2, 16'h0000, 16'h00C0, 1'b0};
    tbl[10] = '{16'h8000, 2'd2, 16'h0000, 16'hFF00, 1'b0};
    tbl[11] = '{16'h0080, 2'd2, 16'h0000, 16'h0080, 1'b0};
    tbl[12] = '{16'hFF80, 2'd2, 16'h0000, 16'hFF80, 1'b0};
    tbl[13] = '{16'hFF00, 2'd0, 16'h001A, 16'hFFE6, 1'b0};
    tbl[14] = '{16'h0280, 2'd0, 16'h001A, 16'h0280, 1'b0};
    tbl[15] = '{16'h8000, 2'd0, 16'h7FFF, 16'h8000, 1'b1};
    tbl[16] = '{16'h8000, 2'd0, 16'h8000, 16'h7FFF, 1'b1};
    tbl[17] = '{16'h0000, 2'd0, 16'h001A, 16'h0000, 1'b0};
    tbl[18] = '{16'hFFFF, 2'd0, 16'h001A, 16'hFFFF, 1'b0};
    tbl[19] = '{16'h8000, 2'd3, 16'h1234, 16'h8000, 1'b0};
    tbl[20] = '{16'h7FFF, 2'd3, 16'h0000, 16'h7FFF, 1'b0};

    sx = '{16'h0100, 16'hFF00, 16'h0080, 16'h1234, 16'h0300, 16'hFE00, 16'h0400, 16'hABCD};
    sm = '{2'd1,     2'd0,     2'd2,     2'd3,     2'd1,     2'd2,     2'd0,     2'd3};
    sa = '{16'h0000, 16'h001A, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0040, 16'h0000};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = '0;
    alpha     = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // table-driven single samples: value, latency and clamp count
    exp_sat = 0;
    for (int i = 0; i < 21; i++) begin
      @(posedge clk);
      #1;
      send(tbl[i].x, tbl[i].mode, tbl[i].a, tbl[i].y);
      in_valid = 1'b0;
      lat = 0;
      got = 0;
      while (!got && lat < 10) begin
        @(negedge clk);
        lat++;
        if (out_valid) got = 1;
      end
      chk($sformatf("latency[%0d]", i), 32'(lat), 32'd3);
      @(negedge clk);
      if (tbl[i].clamp) exp_sat += SAT_INC;
      chk($sformatf("sat_cnt[%0d]", i), 32'(sat_cnt), 32'(exp_sat));
    end

    // 8 back-to-back mixed samples with out_ready low for three cycles
    @(posedge clk);
    #1;
    n0 = n_out;
    saw_in_ready_low = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          rx = model(sx[i], sm[i], sa[i]) & 17'h0FFFF;
          send(sx[i], sm[i], sa[i], rx);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);
    chk("stream_count", 32'(n_out - n0), 32'd8);
    chk("stream_in_ready_dropped", 32'(saw_in_ready_low), 32'd1);

    // reset with two samples held in the pipe
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(16'h0100, 2'd1, 16'h0000, 16'h00C0);
    send(16'h8000, 2'd0, 16'h7FFF, 16'h8000);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sat_cnt", 32'(sat_cnt), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("stale_outputs", 32'(stale), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // PASS soak with random data and random back-pressure
    @(posedge clk);
    #1;
    sat0 = sat_cnt;
    n0   = n_out;
    done = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          rx = 16'($urandom_range(0, 65535));
          send(rx, 2'd3, 16'($urandom_range(0, 65535)), rx);
        end
        in_valid = 1'b0;
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("pass_drained", 32'(exp_q.size()), 32'd0);
    chk("pass_count", 32'(n_out - n0), 32'd1000);
    chk("pass_sat_unchanged", 32'(sat_cnt), 32'(sat0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
